// File: rtl/riscv_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
// Default geometry and the "unknown latency" code.
package riscv_scoreboard_pkg;

    localparam int SB_NREG  = 32;
    localparam int SB_AW    = 5;
    localparam int SB_LAT_W = 3;
    localparam int SB_CNT_W = 32;

    // All-ones latency code: the result arrives on a writeback strobe.
    localparam logic [SB_LAT_W-1:0] SB_LAT_UNKNOWN = '1;

endpackage

// File: rtl/riscv_scoreboard_entry.sv
// One scoreboard slot: a pending bit plus a latency countdown.
// Ports: i_set/i_lat install an entry, i_wb_hit/i_flush_hit free it;
// o_pending is the registered bit, o_busy the effective (blocking) state.
module riscv_scoreboard_entry
    import riscv_scoreboard_pkg::*;
#(
    parameter int LAT_W = SB_LAT_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_set,
    input  logic [LAT_W-1:0] i_lat,
    input  logic             i_wb_hit,
    input  logic             i_flush_hit,
    output logic             o_pending,
    output logic             o_busy
);

    logic             r_pending;
    logic [LAT_W-1:0] r_cnt;
    logic             w_unknown;
    logic             w_last;

    assign w_unknown = (r_cnt == {LAT_W{1'b1}});

    // A fixed entry on its final count clears at this edge, so a
    // dependent presented now may already issue at the same edge.
    assign w_last = r_pending && !w_unknown
                 && (r_cnt == LAT_W'(1));

    assign o_pending = r_pending;
    assign o_busy    = r_pending && !w_last
                    && !i_wb_hit && !i_flush_hit;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else if (i_set) begin
            // A new issue overrides a same-cycle writeback/flush.
            r_pending <= 1'b1;
            r_cnt     <= i_lat;
        end else if (i_wb_hit || i_flush_hit) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else if (r_pending && !w_unknown) begin
            if (w_last) begin
                r_pending <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_scoreboard.sv
// Per-register pending tracker between decode and execute.
// Ports: issue request (rs1/rs2/rd/lat), writeback and flush strobes;
// outputs the decode stall, pending vector, busy count, stall counter.
module riscv_scoreboard
    import riscv_scoreboard_pkg::*;
#(
    parameter int NREG  = SB_NREG,
    parameter int AW    = SB_AW,
    parameter int LAT_W = SB_LAT_W,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_issue_valid,
    input  logic [AW-1:0]    i_issue_rs1,
    input  logic [AW-1:0]    i_issue_rs2,
    input  logic [AW-1:0]    i_issue_rd,
    input  logic             i_issue_rd_we,
    input  logic [LAT_W-1:0] i_issue_lat,
    input  logic             i_wb_valid,
    input  logic [AW-1:0]    i_wb_rd,
    input  logic             i_flush_valid,
    input  logic [AW-1:0]    i_flush_rd,
    output logic             o_issue_stall,
    output logic [NREG-1:0]  o_pending,
    output logic [AW:0]      o_busy_cnt,
    output logic [CNT_W-1:0] o_stall_cycles
);

    logic [NREG-1:0]  w_rs1_dec;
    logic [NREG-1:0]  w_rs2_dec;
    logic [NREG-1:0]  w_rd_dec;
    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_pending;
    logic [NREG-1:1]  w_wb_hit;
    logic [NREG-1:1]  w_flush_hit;
    logic [NREG-1:1]  w_set;
    logic             w_tracked;
    logic             w_stall;
    logic             w_issue_ok;
    logic             w_rs1_haz;
    logic             w_rs2_haz;
    logic             w_rd_haz;
    logic [AW:0]      w_busy_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    for (genvar g = 0; g < NREG; g++) begin : g_dec
        assign w_rs1_dec[g] = (i_issue_rs1 == AW'(g));
        assign w_rs2_dec[g] = (i_issue_rs2 == AW'(g));
        assign w_rd_dec[g]  = (i_issue_rd == AW'(g));
    end

    // x0 never holds a result, so it is never pending.
    assign w_busy[0]    = 1'b0;
    assign w_pending[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_ent
        assign w_wb_hit[g]    = i_wb_valid
                             && (i_wb_rd == AW'(g));
        assign w_flush_hit[g] = i_flush_valid
                             && (i_flush_rd == AW'(g));
        assign w_set[g]       = w_issue_ok && w_tracked
                             && w_rd_dec[g];

        riscv_scoreboard_entry #(
            .LAT_W (LAT_W)
        ) u_entry (
            .i_clk       (i_clk),
            .i_rstn      (i_rstn),
            .i_set       (w_set[g]),
            .i_lat       (i_issue_lat),
            .i_wb_hit    (w_wb_hit[g]),
            .i_flush_hit (w_flush_hit[g]),
            .o_pending   (w_pending[g]),
            .o_busy      (w_busy[g])
        );
    end

    // Only writes with a nonzero latency to a real register are tracked.
    assign w_tracked = i_issue_rd_we
                    && (i_issue_rd != '0)
                    && (i_issue_lat != '0);

    assign w_rs1_haz = |(w_busy & w_rs1_dec);
    assign w_rs2_haz = |(w_busy & w_rs2_dec);
    assign w_rd_haz  = i_issue_rd_we && |(w_busy & w_rd_dec);

    assign w_stall = i_rstn && i_issue_valid
                  && (w_rs1_haz || w_rs2_haz || w_rd_haz);

    assign w_issue_ok = i_issue_valid && !w_stall;

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            w_busy_cnt = w_busy_cnt
                       + {{AW{1'b0}}, w_pending[i]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_issue_stall  = w_stall;
    assign o_pending      = w_pending;
    assign o_busy_cnt     = w_busy_cnt;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Self-checking bench for riscv_scoreboard: directed scenarios plus
// randomized traffic compared every cycle against a timestamp model.
module tb_riscv_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int LAT_W = 3;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;
    localparam int UNK   = (1 << LAT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             iv;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [AW-1:0]    rd;
    logic             we;
    logic [LAT_W-1:0] lat;
    logic             wbv;
    logic [AW-1:0]    wbrd;
    logic             flv;
    logic [AW-1:0]    flrd;
    logic             d_stall;
    logic [NREG-1:0]  d_pend;
    logic [AW:0]      d_busy;
    logic [CNT_W-1:0] d_sc;

    riscv_scoreboard #(
        .NREG  (NREG),
        .AW    (AW),
        .LAT_W (LAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_issue_valid  (iv),
        .i_issue_rs1    (rs1),
        .i_issue_rs2    (rs2),
        .i_issue_rd     (rd),
        .i_issue_rd_we  (we),
        .i_issue_lat    (lat),
        .i_wb_valid     (wbv),
        .i_wb_rd        (wbrd),
        .i_flush_valid  (flv),
        .i_flush_rd     (flrd),
        .o_issue_stall  (d_stall),
        .o_pending      (d_pend),
        .o_busy_cnt     (d_busy),
        .o_stall_cycles (d_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model: each tracked register remembers the edge number at which
    // its fixed result lands (rel), or that it waits for writeback.
    bit m_busy [NREG];
    bit m_unk  [NREG];
    int m_rel  [NREG];
    int m_cyc  = 0;
    int m_sc   = 0;
    bit m_st;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_pend(int r);
        return m_busy[r] && (m_unk[r] || m_cyc < m_rel[r]);
    endfunction

    // Blocking now means: still unresolved after the coming edge.
    function automatic bit m_blk(int r);
        if (wbv && int'(wbrd) == r) return 1'b0;
        if (flv && int'(flrd) == r) return 1'b0;
        return m_busy[r] && (m_unk[r] || m_cyc + 1 < m_rel[r]);
    endfunction

    function automatic bit m_stall();
        if (!rstn || !iv) return 1'b0;
        return m_blk(int'(rs1)) || m_blk(int'(rs2))
            || (we && m_blk(int'(rd)));
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                m_busy[i] = 1'b0;
                m_unk[i]  = 1'b0;
                m_rel[i]  = 0;
            end
            m_cyc = 0;
            m_sc  = 0;
        end else begin
            m_st = m_stall();
            if (m_st && m_sc < SAT) m_sc = m_sc + 1;
            if (wbv) m_busy[wbrd] = 1'b0;
            if (flv) m_busy[flrd] = 1'b0;
            if (iv && !m_st && we && rd != 0 && lat != 0) begin
                m_busy[rd] = 1'b1;
                m_unk[rd]  = (int'(lat) == UNK);
                m_rel[rd]  = m_cyc + 1 + int'(lat);
            end
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NREG-1:0] pv;
            int n;
            n = 0;
            for (int i = 0; i < NREG; i++) begin
                pv[i] = m_pend(i);
                n += int'(pv[i]);
            end
            chk("stall", 64'(d_stall), 64'(m_stall()));
            chk("pending", 64'(d_pend), 64'(pv));
            chk("busy_cnt", 64'(d_busy), 64'(n));
            chk("stall_cycles", 64'(d_sc), 64'(m_sc));
        end
    end

    task automatic idle();
        iv = 0; rs1 = 0; rs2 = 0; rd = 0; we = 0; lat = 0;
        wbv = 0; wbrd = 0; flv = 0; flrd = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int d, input int l,
                         input int s1, input int s2);
        idle();
        iv = 1; we = 1;
        rd = AW'(d); lat = LAT_W'(l);
        rs1 = AW'(s1); rs2 = AW'(s2);
    endtask

    task automatic read(input int s1);
        idle();
        iv = 1; rs1 = AW'(s1);
    endtask

    task automatic do_reset();
        idle();
        rstn = 0;
        step();
        step();
        rstn = 1;
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 7) == 0)
            return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 9));
    endfunction

    initial begin
        rstn = 1;
        idle();
        #2 rstn = 0;
        chk_en = 1;
        #20;
        chk("rst_pending", 64'(d_pend), 64'(0));
        chk("rst_busy", 64'(d_busy), 64'(0));
        chk("rst_sc", 64'(d_sc), 64'(0));
        do_reset();

        // Fixed latency 3: two stall cycles, issue on the third edge.
        issue(5, 3, 0, 0);
        step();
        read(5);
        #1 chk("fix_stall1", 64'(d_stall), 64'(1));
        step();
        #1 chk("fix_stall2", 64'(d_stall), 64'(1));
        step();
        #1 chk("fix_go", 64'(d_stall), 64'(0));
        step();
        idle();
        #1 chk("fix_clear", 64'(d_pend[5]), 64'(0));
        chk("fix_sc", 64'(d_sc), 64'(2));
        chk("fix_model_sc", 64'(m_sc), 64'(2));
        do_reset();

        // Unknown latency: waits for the writeback strobe.
        issue(7, UNK, 0, 0);
        step();
        read(7);
        for (int i = 0; i < 10; i++) begin
            #1 chk("unk_stall", 64'(d_stall), 64'(1));
            step();
        end
        wbv = 1; wbrd = 7;
        #1 chk("unk_wb_go", 64'(d_stall), 64'(0));
        step();
        idle();
        #1 chk("unk_clear", 64'(d_pend[7]), 64'(0));
        chk("unk_sc", 64'(d_sc), 64'(10));
        do_reset();

        // WAW hazard released by a same-cycle flush.
        issue(9, UNK, 0, 0);
        step();
        issue(9, UNK, 0, 0);
        #1 chk("waw_stall", 64'(d_stall), 64'(1));
        flv = 1; flrd = 9;
        #1 chk("waw_flush_go", 64'(d_stall), 64'(0));
        step();
        idle();
        #1 chk("waw_new", 64'(d_pend[9]), 64'(1));
        chk("waw_busy", 64'(d_busy), 64'(1));
        chk("waw_sc", 64'(d_sc), 64'(0));
        do_reset();

        // x0 and latency-0 issues leave nothing pending.
        issue(0, UNK, 0, 0);
        step();
        issue(4, 0, 0, 0);
        step();
        idle();
        #1 chk("x0_pending", 64'(d_pend), 64'(0));
        issue(4, 0, 0, 4);
        #1 chk("x0_read", 64'(d_stall), 64'(0));
        step();
        do_reset();

        // Stall counter saturation at 4 bits.
        issue(3, UNK, 0, 0);
        step();
        read(3);
        repeat (20) step();
        idle();
        #1 chk("sat_sc", 64'(d_sc), 64'(SAT));
        chk("sat_model_sc", 64'(m_sc), 64'(15));
        do_reset();

        // Three concurrent pending registers.
        issue(1, UNK, 0, 0);
        step();
        issue(2, 5, 0, 0);
        step();
        issue(3, 6, 0, 0);
        step();
        idle();
        #1 chk("pop_busy", 64'(d_busy), 64'(3));
        do_reset();

        // Asynchronous reset in the middle of a countdown.
        issue(6, 6, 0, 0);
        step();
        read(6);
        step();
        step();
        #1 chk("mid_sc_pre", 64'(d_sc), 64'(2));
        #1 rstn = 0;
        #1 chk("mid_pending", 64'(d_pend), 64'(0));
        chk("mid_busy", 64'(d_busy), 64'(0));
        chk("mid_sc", 64'(d_sc), 64'(0));
        chk("mid_stall", 64'(d_stall), 64'(0));
        step();
        rstn = 1;
        #1 chk("mid_after", 64'(d_stall), 64'(0));
        step();
        idle();

        // Randomized traffic; the negedge process does the checking.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            iv   = ($urandom_range(0, 3) != 0);
            rs1  = pick();
            rs2  = pick();
            rd   = pick();
            we   = ($urandom_range(0, 4) != 0);
            lat  = LAT_W'($urandom_range(0, UNK));
            wbv  = ($urandom_range(0, 3) == 0);
            wbrd = pick();
            flv  = ($urandom_range(0, 9) == 0);
            flrd = pick();
            step();
        end
        idle();
        step();
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
